gate_bridge_deadtime_unit: RTL and testbench

Parametrised multi-phase bridge output stage for the PMSM gate-driver path. It sits between the PWM/commutation logic and the gate-driver pins. It enforces programmable dead time on every turn-on and blocks shoot-through per phase. It also latches driver faults from the active-low nFAULT line and forces every gate off on fault or disable.

---
 rtl/gate_bridge_deadtime_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_gate_bridge_deadtime_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gate_bridge_deadtime_unit.sv
// -----------------------------------------------------------------------------
// gate_bridge_deadtime_unit
//
// Multi-phase bridge output stage between the PWM/commutation logic and the
// gate-driver pins. Each phase runs a small FSM that inserts a programmable
// dead time before every turn-on. Simultaneous high/low requests are blocked
// and flagged. Driver faults from the active-low nFAULT pin are synchronised
// and latched. A latched fault or a deasserted enable forces every gate off.
//
// Optional build macro:
//   GATE_BRIDGE_NFAULT_FILTER_EN - a fault is accepted only after nfault_s has
//                                  been low for FILTER_LEN consecutive cycles.
//                                  Without it, nfault_s is used directly.
//
// Ports:
//   sys_clk                in  system clock, rising edge
//   reset_n                in  asynchronous active-low reset
//   bridge_enable_in       in  1 = bridge allowed to switch
//   dead_time_in           in  dead time in cycles, sampled on DT-state entry
//   high_side_in           in  per-phase high-side request
//   low_side_in            in  per-phase low-side request
//   gate_driver_nfault_in  in  driver fault, active low, asynchronous
//   fault_clear_in         in  single-cycle pulse, clears the latched fault
//   high_side_out          out registered high-side gates
//   low_side_out           out registered low-side gates
//   fault_latched_out      out sticky driver fault
//   shoot_through_err_out  out sticky per-phase "both sides requested" flag
// -----------------------------------------------------------------------------
module gate_bridge_deadtime_unit #(
   parameter int PHASE_NUM  = 3,
   parameter int DT_WIDTH   = 8,
   parameter int FILTER_LEN = 4
) (
   input  logic                 sys_clk,
   input  logic                 reset_n,
   input  logic                 bridge_enable_in,
   input  logic [DT_WIDTH-1:0]  dead_time_in,
   input  logic [PHASE_NUM-1:0] high_side_in,
   input  logic [PHASE_NUM-1:0] low_side_in,
   input  logic                 gate_driver_nfault_in,
   input  logic                 fault_clear_in,
   output logic [PHASE_NUM-1:0] high_side_out,
   output logic [PHASE_NUM-1:0] low_side_out,
   output logic                 fault_latched_out,
   output logic [PHASE_NUM-1:0] shoot_through_err_out
);

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_DT_HIGH = 3'd1,
      ST_HIGH_ON = 3'd2,
      ST_DT_LOW  = 3'd3,
      ST_LOW_ON  = 3'd4
   } state_t;

   if (FILTER_LEN < 1) begin : g_bad_filter_len
      $error("FILTER_LEN must be at least 1");
   end

   // The synchroniser stores the inverted pin (1 = fault) so that its reset
   // value of 0 reads as "no fault" and a reset never latches a fault.
   logic fault_sync1_q;
   logic fault_sync2_q;
   logic nfault_s;
   logic fault_acc;
   logic fault_q;
   logic fault_set;
   logic fault_clr;
   logic kill;

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         fault_sync1_q <= 1'b0;
         fault_sync2_q <= 1'b0;
      end else begin
         fault_sync1_q <= ~gate_driver_nfault_in;
         fault_sync2_q <= fault_sync1_q;
      end
   end

   assign nfault_s = ~fault_sync2_q;

`ifdef GATE_BRIDGE_NFAULT_FILTER_EN
   localparam int FILT_W = $clog2(FILTER_LEN + 1);
   localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILTER_LEN);

   logic [FILT_W-1:0] filt_cnt_q;
   logic [FILT_W-1:0] filt_cnt_d;

   // Counts consecutive low samples, saturates, and restarts on any high.
   always_comb begin
      filt_cnt_d = filt_cnt_q;
      if (nfault_s) begin
         filt_cnt_d = '0;
      end else if (filt_cnt_q != FILT_MAX) begin
         filt_cnt_d = filt_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         filt_cnt_q <= '0;
      end else begin
         filt_cnt_q <= filt_cnt_d;
      end
   end

   assign fault_acc = (filt_cnt_q == FILT_MAX);
`else
   assign fault_acc = ~nfault_s;
`endif

   assign fault_set = fault_acc;
   assign fault_clr = fault_clear_in & nfault_s;

   // Set has priority over a coincident clear.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         fault_q <= 1'b0;
      end else if (fault_set) begin
         fault_q <= 1'b1;
      end else if (fault_clr) begin
         fault_q <= 1'b0;
      end
   end

   assign fault_latched_out = fault_q;

   // A fault being set on this edge already kills the outputs on this edge.
   assign kill = ~bridge_enable_in | fault_q | fault_set;

   for (genvar i = 0; i < PHASE_NUM; i++) begin : g_phase
      state_t              state_q;
      state_t              state_d;
      logic [DT_WIDTH-1:0] cnt_q;
      logic [DT_WIDTH-1:0] cnt_d;
      logic                hs_q;
      logic                ls_q;
      logic                st_err_q;
      logic                req_h;
      logic                req_l;
      logic                req_bad;

      // An illegal 11 request decodes as neither side, i.e. as NONE.
      assign req_h   = high_side_in[i] & ~low_side_in[i];
      assign req_l   = low_side_in[i]  & ~high_side_in[i];
      assign req_bad = high_side_in[i] &  low_side_in[i];

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         if (kill) begin
            state_d = ST_OFF;
         end else begin
            case (state_q)
               ST_OFF: begin
                  if (req_h) begin
                     state_d = ST_DT_HIGH;
                     cnt_d   = dead_time_in;
                  end else if (req_l) begin
                     state_d = ST_DT_LOW;
                     cnt_d   = dead_time_in;
                  end
               end
               ST_DT_HIGH: begin
                  if (req_h) begin
                     if (cnt_q == '0) begin
                        state_d = ST_HIGH_ON;
                     end else begin
                        cnt_d = cnt_q - 1'b1;
                     end
                  end else if (req_l) begin
                     state_d = ST_DT_LOW;
                     cnt_d   = dead_time_in;
                  end else begin
                     state_d = ST_OFF;
                  end
               end
               ST_HIGH_ON: begin
                  if (req_l) begin
                     state_d = ST_DT_LOW;
                     cnt_d   = dead_time_in;
                  end else if (!req_h) begin
                     state_d = ST_OFF;
                  end
               end
               ST_DT_LOW: begin
                  if (req_l) begin
                     if (cnt_q == '0) begin
                        state_d = ST_LOW_ON;
                     end else begin
                        cnt_d = cnt_q - 1'b1;
                     end
                  end else if (req_h) begin
                     state_d = ST_DT_HIGH;
                     cnt_d   = dead_time_in;
                  end else begin
                     state_d = ST_OFF;
                  end
               end
               ST_LOW_ON: begin
                  if (req_h) begin
                     state_d = ST_DT_HIGH;
                     cnt_d   = dead_time_in;
                  end else if (!req_l) begin
                     state_d = ST_OFF;
                  end
               end
               default: begin
                  state_d = ST_OFF;
               end
            endcase
         end
      end

      // Gate outputs are registered decodes of the next state, so they always
      // match the state register and can never be high together.
      always_ff @(posedge sys_clk or negedge reset_n) begin
         if (!reset_n) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            hs_q     <= 1'b0;
            ls_q     <= 1'b0;
            st_err_q <= 1'b0;
         end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hs_q     <= (state_d == ST_HIGH_ON);
            ls_q     <= (state_d == ST_LOW_ON);
            st_err_q <= st_err_q | req_bad;
         end
      end

      assign high_side_out[i]         = hs_q;
      assign low_side_out[i]          = ls_q;
      assign shoot_through_err_out[i] = st_err_q;
   end

endmodule

// File: tb/tb_gate_bridge_deadtime_unit.sv
module tb_gate_bridge_deadtime_unit;

   localparam int PN  = 3;
   localparam int DTW = 8;
   localparam int FLEN = 4;
`ifdef GATE_BRIDGE_NFAULT_FILTER_EN
   localparam int FAULT_LAT = 3 + FLEN;
`else
   localparam int FAULT_LAT = 3;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           en;
   logic [DTW-1:0] dt;
   logic [PN-1:0]  hi;
   logic [PN-1:0]  lo;
   logic           nf;
   logic           clr;
   logic [PN-1:0]  hs;
   logic [PN-1:0]  ls;
   logic           flt;
   logic [PN-1:0]  st;

   int checks   = 0;
   int failures = 0;

   gate_bridge_deadtime_unit #(
      .PHASE_NUM (PN),
      .DT_WIDTH  (DTW),
      .FILTER_LEN(FLEN)
   ) dut (
      .sys_clk              (clk),
      .reset_n              (rst_n),
      .bridge_enable_in     (en),
      .dead_time_in         (dt),
      .high_side_in         (hi),
      .low_side_in          (lo),
      .gate_driver_nfault_in(nf),
      .fault_clear_in       (clr),
      .high_side_out        (hs),
      .low_side_out         (ls),
      .fault_latched_out    (flt),
      .shoot_through_err_out(st)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic           en;
      logic [DTW-1:0] dt;
      logic [PN-1:0]  hi;
      logic [PN-1:0]  lo;
      int             reps;
      logic [PN-1:0]  ehi;
      logic [PN-1:0]  elo;
      logic [PN-1:0]  est;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic e, input logic [DTW-1:0] d,
                               input logic [PN-1:0] h, input logic [PN-1:0] l,
                               input int n, input logic [PN-1:0] eh,
                               input logic [PN-1:0] el, input logic [PN-1:0] es);
      vec_t v;
      v.en = e; v.dt = d; v.hi = h; v.lo = l; v.reps = n;
      v.ehi = eh; v.elo = el; v.est = es;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_outs(input string tag, input logic [PN-1:0] ehi, input logic [PN-1:0] elo,
                           input logic ef, input logic [PN-1:0] est);
      chk({tag, ".high"},  32'(hs),  32'(ehi));
      chk({tag, ".low"},   32'(ls),  32'(elo));
      chk({tag, ".fault"}, 32'(flt), 32'(ef));
      chk({tag, ".st"},    32'(st),  32'(est));
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // Table: phase 0 HIGH/LOW swaps with dt=5, DT_LOW reversal at cnt=3,
      // phase 1 illegal request, dt=0 on phase 2, dt change mid-dead-time,
      // disable/re-enable and all-off.
      tbl.push_back(mk(1, 5, 3'b001, 3'b000,  6, 3'b000, 3'b000, 3'b000));
      tbl.push_back(mk(1, 5, 3'b001, 3'b000, 14, 3'b001, 3'b000, 3'b000));
      tbl.push_back(mk(1, 5, 3'b000, 3'b001,  6, 3'b000, 3'b000, 3'b000));
      tbl.push_back(mk(1, 5, 3'b000, 3'b001,  2, 3'b000, 3'b001, 3'b000));
      tbl.push_back(mk(1, 5, 3'b001, 3'b000,  6, 3'b000, 3'b000, 3'b000));
      tbl.push_back(mk(1, 5, 3'b001, 3'b000,  2, 3'b001, 3'b000, 3'b000));
      tbl.push_back(mk(1, 5, 3'b000, 3'b001,  3, 3'b000, 3'b000, 3'b000));
      tbl.push_back(mk(1, 5, 3'b001, 3'b000,  6, 3'b000, 3'b000, 3'b000));
      tbl.push_back(mk(1, 5, 3'b001, 3'b000,  2, 3'b001, 3'b000, 3'b000));
      tbl.push_back(mk(1, 5, 3'b011, 3'b010,  2, 3'b001, 3'b000, 3'b010));
      tbl.push_back(mk(1, 5, 3'b001, 3'b010,  6, 3'b001, 3'b000, 3'b010));
      tbl.push_back(mk(1, 5, 3'b001, 3'b010,  2, 3'b001, 3'b010, 3'b010));
      tbl.push_back(mk(1, 0, 3'b101, 3'b010,  1, 3'b001, 3'b010, 3'b010));
      tbl.push_back(mk(1, 0, 3'b101, 3'b010,  2, 3'b101, 3'b010, 3'b010));
      tbl.push_back(mk(1, 2, 3'b001, 3'b110,  1, 3'b001, 3'b010, 3'b010));
      tbl.push_back(mk(1, 9, 3'b001, 3'b110,  2, 3'b001, 3'b010, 3'b010));
      tbl.push_back(mk(1, 9, 3'b001, 3'b110,  2, 3'b001, 3'b110, 3'b010));
      tbl.push_back(mk(0, 9, 3'b011, 3'b110,  2, 3'b000, 3'b000, 3'b010));
      tbl.push_back(mk(1, 1, 3'b001, 3'b110,  2, 3'b000, 3'b000, 3'b010));
      tbl.push_back(mk(1, 1, 3'b001, 3'b110,  2, 3'b001, 3'b110, 3'b010));
      tbl.push_back(mk(1, 1, 3'b000, 3'b000,  1, 3'b000, 3'b000, 3'b010));
      tbl.push_back(mk(1, 1, 3'b001, 3'b110,  2, 3'b000, 3'b000, 3'b010));
      tbl.push_back(mk(1, 1, 3'b001, 3'b110,  3, 3'b001, 3'b110, 3'b010));

      rst_n = 1'b0; en = 1'b0; dt = '0; hi = '0; lo = '0; nf = 1'b1; clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_outs("reset", 3'b000, 3'b000, 1'b0, 3'b000);
      rst_n = 1'b1;

      for (int r = 0; r < tbl.size(); r++) begin
         en = tbl[r].en; dt = tbl[r].dt; hi = tbl[r].hi; lo = tbl[r].lo;
         for (int k = 0; k < tbl[r].reps; k++) begin
            step();
            chk_outs($sformatf("row%0d.%0d", r, k), tbl[r].ehi, tbl[r].elo, 1'b0, tbl[r].est);
         end
      end

      // Fault: pin low, latched after FAULT_LAT edges with outputs forced off.
      nf = 1'b0;
      for (int k = 1; k < FAULT_LAT; k++) step();
      chk_outs("flt_pre", 3'b001, 3'b110, 1'b0, 3'b010);
      step();
      chk_outs("flt_set", 3'b000, 3'b000, 1'b1, 3'b010);
      for (int k = FAULT_LAT; k < 10; k++) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk_outs("clr_ignored", 3'b000, 3'b000, 1'b1, 3'b010);
      nf = 1'b1;
      repeat (3) step();
      chk_outs("flt_held", 3'b000, 3'b000, 1'b1, 3'b010);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk_outs("clr_done", 3'b000, 3'b000, 1'b0, 3'b010);
      for (int k = 0; k < 2; k++) begin
         step();
         chk_outs($sformatf("resume_dt%0d", k), 3'b000, 3'b000, 1'b0, 3'b010);
      end
      step();
      chk_outs("resume_on", 3'b001, 3'b110, 1'b0, 3'b010);

`ifdef GATE_BRIDGE_NFAULT_FILTER_EN
      // Short glitch is rejected by the filter.
      nf = 1'b0;
      repeat (2) step();
      nf = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         chk_outs($sformatf("glitch%0d", k), 3'b001, 3'b110, 1'b0, 3'b010);
      end
`endif

      // Asynchronous reset mid-dead-time (phase 0) and mid-ON (phases 1, 2).
      dt = 8'd3; hi = 3'b000; lo = 3'b111;
      step();
      chk_outs("pre_rst0", 3'b000, 3'b110, 1'b0, 3'b010);
      step();
      chk_outs("pre_rst1", 3'b000, 3'b110, 1'b0, 3'b010);
      #2 rst_n = 1'b0;
      #1 chk_outs("async_rst", 3'b000, 3'b000, 1'b0, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      dt = 8'd1;
      for (int k = 0; k < 2; k++) begin
         step();
         chk_outs($sformatf("post_rst_dt%0d", k), 3'b000, 3'b000, 1'b0, 3'b000);
      end
      step();
      chk_outs("post_rst_on", 3'b000, 3'b111, 1'b0, 3'b000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
